// File: rtl/atm_pkg.sv
// ---------------------------------------------------------------------------
// atm_pkg
//  Shared definitions for the ATM keypad path: key codes delivered by the
//  keypad scanner, the entry-state encoding that atm_pin_entry reports on
//  its entry_state port, and a small key-classification helper.
//  Used by the PIN collector, the ATM controller and their benches.
// ---------------------------------------------------------------------------
package atm_pkg;

  // Non-digit key codes. Codes 0x0-0x9 are digits and 0xD-0xF are illegal.
  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  // Entry FSM encoding; the values are visible on the entry_state port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_RESULT  = 2'b10
  } entry_state_e;

  // True for the ten decimal digit keys.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_timeout_timer.sv
// ---------------------------------------------------------------------------
// atm_timeout_timer
//  Inactivity timer. The count is the number of enabled cycles since the
//  most recent clear cycle; the clear cycle itself is cycle 0. expired is
//  raised while enabled and the count has reached TIMEOUT_CYCLES-1, so an
//  event cleared in cycle N expires in cycle N+TIMEOUT_CYCLES-1.
//  The count saturates at TIMEOUT_CYCLES-1 so expired stays up until the
//  owner clears the timer.
//
// Ports
//  clk      in   rising-edge clock
//  reset    in   synchronous active-high reset, count to 0
//  clear    in   restart counting from this cycle
//  enable   in   count this cycle (count holds when low)
//  expired  out  timeout reached (combinational from the count register)
// ---------------------------------------------------------------------------
module atm_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] base;

  // clear takes effect in the current cycle: the cleared cycle counts as 0,
  // and if the timer is enabled the next cycle already reads 1.
  always_comb begin
    base    = clear ? '0 : count_q;
    count_d = base;
    if (enable && (base != LAST)) begin
      count_d = base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/atm_pin_entry.sv
// ---------------------------------------------------------------------------
// atm_pin_entry
//  Keypad-side PIN collector and verifier. While a card is present it
//  collects BCD digits into a shift buffer, and on ENTER with a full buffer
//  compares them with the card's stored PIN. The result is reported to the
//  ATM controller as a one-cycle pin_entered pulse with pin_correct valid
//  alongside it. Attempt counting / card blocking live in the controller.
//
// Ports
//  clk            in   rising-edge clock
//  reset          in   synchronous active-high reset
//  card_inserted  in   level; entry enabled only while high
//  key_valid      in   one-cycle strobe qualifying key_code
//  key_code       in   4-bit key (0-9 digit, A CLEAR, B ENTER, C CANCEL)
//  stored_pin     in   reference PIN, BCD, MS digit first, sampled at ENTER
//  pin_entered    out  one-cycle pulse: attempt completed
//  pin_correct    out  attempt result, held until next attempt/CANCEL/removal
//  digit_count    out  digits currently buffered (masked display)
//  entry_state    out  FSM state (00 IDLE, 01 COLLECT, 10 RESULT)
//  key_error      out  one-cycle pulse the cycle after a rejected key
//  timeout        out  one-cycle pulse in the cycle the inter-key timer fires
//
// Handshake: key_valid is a strobe with no back-pressure. A key is consumed
// in the cycle it is presented; keys outside COLLECT are dropped silently.
// ---------------------------------------------------------------------------
module atm_pin_entry
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    card_inserted,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic [4*PIN_DIGITS-1:0] stored_pin,
  output logic                    pin_entered,
  output logic                    pin_correct,
  output logic [2:0]              digit_count,
  output logic [1:0]              entry_state,
  output logic                    key_error,
  output logic                    timeout
);

  localparam int         BUF_W = 4 * PIN_DIGITS;
  localparam logic [2:0] FULL  = 3'(PIN_DIGITS);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  entry_state_e     state_q, state_d;
  logic [BUF_W-1:0] pin_buf_q, pin_buf_d;
  logic [2:0]       count_q, count_d;
  logic             pin_correct_q, pin_correct_d;
  logic             key_error_q, key_error_d;

  // -------------------------------------------------------------------------
  // Shared decode
  // -------------------------------------------------------------------------
  logic in_collect;
  logic live_key;     // key accepted for processing this cycle
  logic timer_clear;
  logic timer_enable;
  logic timer_expired;
  logic tmo_fire;     // timeout takes effect this cycle

  assign in_collect = (state_q == ST_COLLECT);
  assign live_key   = in_collect && card_inserted && key_valid;

  // Card removal and a same-cycle key both take precedence over expiry.
  assign tmo_fire   = in_collect && card_inserted && !key_valid && timer_expired;

  // The timer only runs in COLLECT. Clearing it everywhere else means it
  // always starts from zero on entering COLLECT. It is also restarted on
  // every key and on its own expiry so a long idle gives periodic pulses.
  assign timer_enable = in_collect;
  assign timer_clear  = !in_collect || !card_inserted || key_valid || timer_expired;

  atm_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (card_inserted) begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (!card_inserted) begin
          state_d = ST_IDLE;
        end else if (key_valid && (key_code == KEY_ENTER) && (count_q == FULL)) begin
          state_d = ST_RESULT;
        end else if (key_valid && (key_code == KEY_CANCEL)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RESULT: begin
        // RESULT lasts exactly one cycle; the user may retry straight away.
        state_d = card_inserted ? ST_COLLECT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: PIN buffer, digit count, compare result, key error
  // -------------------------------------------------------------------------
  always_comb begin
    pin_buf_d     = pin_buf_q;
    count_d       = count_q;
    pin_correct_d = pin_correct_q;
    key_error_d   = 1'b0;

    if (!card_inserted) begin
      // Removal wins over anything else presented in the same cycle.
      pin_buf_d     = '0;
      count_d       = '0;
      pin_correct_d = 1'b0;
    end else if (state_q != ST_COLLECT) begin
      // IDLE and RESULT never hold digits; the next COLLECT starts empty.
      pin_buf_d = '0;
      count_d   = '0;
    end else if (live_key) begin
      if (is_digit(key_code)) begin
        if (count_q < FULL) begin
          pin_buf_d = {pin_buf_q[BUF_W-5:0], key_code};
          count_d   = count_q + 3'd1;
        end else begin
          key_error_d = 1'b1;
        end
      end else begin
        unique case (key_code)
          KEY_CLEAR: begin
            pin_buf_d = '0;
            count_d   = '0;
          end
          KEY_ENTER: begin
            if (count_q == FULL) begin
              // Compare is registered here and presented during RESULT.
              // The digits are wiped at the same edge so they never
              // outlive the attempt.
              pin_correct_d = (pin_buf_q == stored_pin);
              pin_buf_d     = '0;
              count_d       = '0;
            end else begin
              key_error_d = 1'b1;
            end
          end
          KEY_CANCEL: begin
            pin_buf_d     = '0;
            count_d       = '0;
            pin_correct_d = 1'b0;
          end
          default: begin
            key_error_d = 1'b1;
          end
        endcase
      end
    end else if (tmo_fire) begin
      pin_buf_d = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pin_buf_q     <= '0;
      count_q       <= '0;
      pin_correct_q <= 1'b0;
      key_error_q   <= 1'b0;
    end else begin
      pin_buf_q     <= pin_buf_d;
      count_q       <= count_d;
      pin_correct_q <= pin_correct_d;
      key_error_q   <= key_error_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    pin_entered = (state_q == ST_RESULT);
    pin_correct = pin_correct_q;
    digit_count = count_q;
    entry_state = state_q;
    key_error   = key_error_q;
    // Combinational so that a key arriving in the expiry cycle can cancel
    // the pulse in that same cycle.
    timeout     = tmo_fire;
  end

endmodule

// File: tb/tb_atm_pin_entry.sv
module tb_atm_pin_entry;
  import atm_pkg::*;

  localparam int PIN_DIGITS     = 4;
  localparam int TIMEOUT_CYCLES = 8;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        card_inserted;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] stored_pin;
  logic        pin_entered;
  logic        pin_correct;
  logic [2:0]  digit_count;
  logic [1:0]  entry_state;
  logic        key_error;
  logic        timeout;

  always #5 clk = ~clk;

  atm_pin_entry #(
    .PIN_DIGITS    (PIN_DIGITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .card_inserted(card_inserted),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .stored_pin   (stored_pin),
    .pin_entered  (pin_entered),
    .pin_correct  (pin_correct),
    .digit_count  (digit_count),
    .entry_state  (entry_state),
    .key_error    (key_error),
    .timeout      (timeout)
  );

  int total_cnt   = 0;
  int pass_cnt    = 0;
  int entered_cnt = 0;

  // ---------------------------------------------------------------------
  // Scoreboard: one expected pin_correct per ENTER that should complete
  // ---------------------------------------------------------------------
  logic [0:0] exp_q[$];
  logic [0:0] sb_exp;

  always @(negedge clk) begin
    if (!reset && pin_entered) begin
      entered_cnt++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_attempt got pin_entered=1 want no attempt pending (t=%0t)", $time);
      end else begin
        sb_exp = exp_q.pop_front();
        if (pin_correct !== sb_exp[0])
          $display("FAIL sb_pin_correct got %b want %b (t=%0t)", pin_correct, sb_exp[0], $time);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no end of test want finish before 200us");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Remove then insert the card; returns in the first COLLECT cycle.
  task automatic start_session();
    card_inserted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    card_inserted = 1'b1;
    @(posedge clk); #1;
  endtask

  // Four digits then ENTER; returns just after the edge into RESULT.
  task automatic enter_pin(input logic [15:0] digits);
    for (int i = 3; i >= 0; i--) press(digits[4*i +: 4]);
    exp_q.push_back(digits == stored_pin);
    press(KEY_ENTER);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; card_inserted = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    stored_pin = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (entry_state !== 2'b00) $display("FAIL reset_state got %b want 00", entry_state); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL reset_count got %0d want 0", digit_count); else pass_cnt++;
    total_cnt++; if (pin_entered !== 1'b0) $display("FAIL reset_entered got %b want 0", pin_entered); else pass_cnt++;
    total_cnt++; if (pin_correct !== 1'b0) $display("FAIL reset_correct got %b want 0", pin_correct); else pass_cnt++;
    total_cnt++; if (key_error !== 1'b0) $display("FAIL reset_key_error got %b want 0", key_error); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_correct_pin();
    start_session();
    total_cnt++; if (entry_state !== 2'b01) $display("FAIL correct_enter_collect got %b want 01", entry_state); else pass_cnt++;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    @(negedge clk);
    total_cnt++; if (digit_count !== 3'd4) $display("FAIL correct_count4 got %0d want 4", digit_count); else pass_cnt++;
    exp_q.push_back(1'b1);
    press(KEY_ENTER);
    @(negedge clk);
    total_cnt++; if (pin_entered !== 1'b1) $display("FAIL correct_entered got %b want 1", pin_entered); else pass_cnt++;
    total_cnt++; if (entry_state !== 2'b10) $display("FAIL correct_result_state got %b want 10", entry_state); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL correct_count0 got %0d want 0", digit_count); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (pin_entered !== 1'b0) $display("FAIL correct_pulse_width got %b want 0", pin_entered); else pass_cnt++;
    total_cnt++; if (entry_state !== 2'b01) $display("FAIL correct_back_collect got %b want 01", entry_state); else pass_cnt++;
    total_cnt++; if (pin_correct !== 1'b1) $display("FAIL correct_held got %b want 1", pin_correct); else pass_cnt++;
  endtask

  task automatic test_wrong_pin();
    int base;
    start_session();
    base = entered_cnt;
    for (int i = 0; i < 3; i++) begin
      enter_pin(16'h1235);
      @(negedge clk);
      total_cnt++; if (pin_entered !== 1'b1) $display("FAIL wrong_entered[%0d] got %b want 1", i, pin_entered); else pass_cnt++;
      total_cnt++; if (pin_correct !== 1'b0) $display("FAIL wrong_correct[%0d] got %b want 0", i, pin_correct); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (entry_state !== 2'b01) $display("FAIL wrong_state[%0d] got %b want 01", i, entry_state); else pass_cnt++;
    end
    total_cnt++; if (entered_cnt - base !== 3) $display("FAIL wrong_attempts got %0d want 3", entered_cnt - base); else pass_cnt++;
  endtask

  task automatic test_editing();
    start_session();
    press(4'd9); press(4'd9); press(KEY_CLEAR);
    @(negedge clk);
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL edit_clear got %0d want 0", digit_count); else pass_cnt++;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    @(negedge clk);
    total_cnt++; if (key_error !== 1'b1) $display("FAIL edit_overflow_err got %b want 1", key_error); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd4) $display("FAIL edit_overflow_count got %0d want 4", digit_count); else pass_cnt++;
    exp_q.push_back(16'h1234 == stored_pin);
    press(KEY_ENTER);
    @(negedge clk);
    total_cnt++; if (pin_entered !== 1'b1) $display("FAIL edit_entered got %b want 1", pin_entered); else pass_cnt++;
    total_cnt++; if (pin_correct !== 1'b1) $display("FAIL edit_correct got %b want 1", pin_correct); else pass_cnt++;
  endtask

  task automatic test_short_enter();
    int base;
    start_session();
    base = entered_cnt;
    press(4'd1); press(4'd2); press(KEY_ENTER);
    @(negedge clk);
    total_cnt++; if (key_error !== 1'b1) $display("FAIL short_err got %b want 1", key_error); else pass_cnt++;
    total_cnt++; if (pin_entered !== 1'b0) $display("FAIL short_entered got %b want 0", pin_entered); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd2) $display("FAIL short_count got %0d want 2", digit_count); else pass_cnt++;
    total_cnt++; if (entry_state !== 2'b01) $display("FAIL short_state got %b want 01", entry_state); else pass_cnt++;
    press(4'hE);
    @(negedge clk);
    total_cnt++; if (key_error !== 1'b1) $display("FAIL illegal_err got %b want 1", key_error); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd2) $display("FAIL illegal_count got %0d want 2", digit_count); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (key_error !== 1'b0) $display("FAIL err_pulse_width got %b want 0", key_error); else pass_cnt++;
    total_cnt++; if (entered_cnt !== base) $display("FAIL short_attempts got %0d want %0d", entered_cnt, base); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int base;
    start_session();
    base = entered_cnt;
    press(4'd1);
    for (int i = 1; i <= TIMEOUT_CYCLES - 2; i++) begin
      @(negedge clk);
      total_cnt++; if (timeout !== 1'b0) $display("FAIL timeout_early[%0d] got %b want 0", i, timeout); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (timeout !== 1'b1) $display("FAIL timeout_fire got %b want 1", timeout); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (timeout !== 1'b0) $display("FAIL timeout_width got %b want 0", timeout); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL timeout_count got %0d want 0", digit_count); else pass_cnt++;
    total_cnt++; if (entry_state !== 2'b01) $display("FAIL timeout_state got %b want 01", entry_state); else pass_cnt++;
    // A key landing exactly in the expiry cycle wins over the timeout.
    press(4'd3);
    repeat (TIMEOUT_CYCLES - 2) @(negedge clk);
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = 4'd4;
    @(negedge clk);
    total_cnt++; if (timeout !== 1'b0) $display("FAIL timeout_suppress got %b want 0", timeout); else pass_cnt++;
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 4'h0;
    @(negedge clk);
    total_cnt++; if (digit_count !== 3'd2) $display("FAIL timeout_key_kept got %0d want 2", digit_count); else pass_cnt++;
    total_cnt++; if (entered_cnt !== base) $display("FAIL timeout_attempts got %0d want %0d", entered_cnt, base); else pass_cnt++;
  endtask

  task automatic test_cancel();
    start_session();
    enter_pin(16'h1234);
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (pin_correct !== 1'b1) $display("FAIL cancel_pre_correct got %b want 1", pin_correct); else pass_cnt++;
    press(4'd5); press(4'd6); press(KEY_CANCEL);
    @(negedge clk);
    total_cnt++; if (entry_state !== 2'b00) $display("FAIL cancel_state got %b want 00", entry_state); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL cancel_count got %0d want 0", digit_count); else pass_cnt++;
    total_cnt++; if (pin_correct !== 1'b0) $display("FAIL cancel_correct got %b want 0", pin_correct); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (entry_state !== 2'b01) $display("FAIL cancel_recollect got %b want 01", entry_state); else pass_cnt++;
  endtask

  task automatic test_removal_race();
    start_session();
    enter_pin(16'h1234);
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (pin_correct !== 1'b1) $display("FAIL race_pre_correct got %b want 1", pin_correct); else pass_cnt++;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    card_inserted = 1'b0; key_valid = 1'b1; key_code = KEY_ENTER;
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 4'h0;
    @(negedge clk);
    total_cnt++; if (pin_entered !== 1'b0) $display("FAIL race_entered got %b want 0", pin_entered); else pass_cnt++;
    total_cnt++; if (entry_state !== 2'b00) $display("FAIL race_state got %b want 00", entry_state); else pass_cnt++;
    total_cnt++; if (pin_correct !== 1'b0) $display("FAIL race_correct got %b want 0", pin_correct); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL race_count got %0d want 0", digit_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    start_session();
    enter_pin(16'h1234);
    @(posedge clk); #1;
    press(4'd1); press(4'd2); press(4'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++; if (entry_state !== 2'b00) $display("FAIL midreset_state got %b want 00", entry_state); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL midreset_count got %0d want 0", digit_count); else pass_cnt++;
    total_cnt++; if (pin_correct !== 1'b0) $display("FAIL midreset_correct got %b want 0", pin_correct); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++; if (entry_state !== 2'b01) $display("FAIL midreset_resume got %b want 01", entry_state); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int base;
    logic [15:0] pin;
    start_session();
    base = entered_cnt;
    enter_pin(16'h1234);
    // Key during the RESULT cycle must vanish without error.
    press(4'd7);
    @(negedge clk);
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL result_key_count got %0d want 0", digit_count); else pass_cnt++;
    total_cnt++; if (key_error !== 1'b0) $display("FAIL result_key_err got %b want 0", key_error); else pass_cnt++;
    total_cnt++; if (entry_state !== 2'b01) $display("FAIL result_key_state got %b want 01", entry_state); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      stored_pin = rand_bcd();
      pin = ($urandom_range(0, 1) == 1) ? stored_pin : rand_bcd();
      enter_pin(pin);
      @(posedge clk); #1;
    end
    @(negedge clk);
    total_cnt++; if (entered_cnt - base !== 7) $display("FAIL b2b_attempts got %0d want 7", entered_cnt - base); else pass_cnt++;
    stored_pin = 16'h1234;
  endtask

  // ---------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------
  initial begin
    test_reset();
    test_correct_pin();
    test_wrong_pin();
    test_editing();
    test_short_enter();
    test_timeout();
    test_cancel();
    test_removal_race();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    total_cnt++; if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d pending want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
